// File: rtl/wb_timer.sv
// Wishbone classic interval timer: 32-bit down-counter with prescaler, auto-reload and IRQ.
// Define WB_TIMER_CYCLECNT_EN to expose a 64-bit free-running cycle counter at address 4.
module wb_timer #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64,
    parameter int PRESCALE   = 1
) (
    input  logic                    sys_clock_i,
    input  logic                    sys_reset_i,
    input  logic                    wbs_cycle_i,
    input  logic                    wbs_strobe_i,
    input  logic                    wbs_we_i,
    input  logic [ADDR_WIDTH-1:0]   wbs_addr_i,
    input  logic [DATA_WIDTH-1:0]   wbs_data_i,
    input  logic [DATA_WIDTH/8-1:0] wbs_sel_i,
    output logic                    wbs_ack_o,
    output logic [DATA_WIDTH-1:0]   wbs_data_o,
    output logic                    irq_o
);
    localparam int PW = $clog2(PRESCALE) + 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    typedef enum logic [2:0] {
        REG_CTRL   = 3'd0,
        REG_LOAD   = 3'd1,
        REG_COUNT  = 3'd2,
        REG_STATUS = 3'd3,
        REG_CYCLES = 3'd4
    } reg_e;

    logic                  en, periodic, irq_en, expired;
    logic [31:0]           load, count;
    logic [PW-1:0]         presc;
    logic                  req, wr, tick, ctrl_wr;
    logic [2:0]            reg_sel;
    logic [DATA_WIDTH-1:0] rd_val;
    logic                  unused_bits;

    assign req     = wbs_cycle_i & wbs_strobe_i & ~wbs_ack_o;
    assign wr      = req & wbs_we_i;
    assign reg_sel = wbs_addr_i[5:3];
    assign tick    = en && (presc == PRESC_LAST);
    assign ctrl_wr = wr && (reg_sel == REG_CTRL) && wbs_sel_i[0];
    assign irq_o   = expired & irq_en;

    assign unused_bits = ^{wbs_addr_i[ADDR_WIDTH-1:6], wbs_addr_i[2:0],
                           wbs_data_i[DATA_WIDTH-1:32], wbs_sel_i[DATA_WIDTH/8-1:4]};

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] val,
                                          input logic [3:0] be);
        logic [31:0] res;
        res = old;
        for (int unsigned i = 0; i < 4; i++)
            if (be[i]) res[8*i +: 8] = val[8*i +: 8];
        return res;
    endfunction

`ifdef WB_TIMER_CYCLECNT_EN
    logic [63:0] cycles;

    always_ff @(posedge sys_clock_i) begin
        if (sys_reset_i) cycles <= '0;
        else             cycles <= cycles + 64'd1;
    end
`endif

    always_comb begin
        rd_val = '0;
        case (reg_sel)
            REG_CTRL:   rd_val[2:0]  = {irq_en, periodic, en};
            REG_LOAD:   rd_val[31:0] = load;
            REG_COUNT:  rd_val[31:0] = count;
            REG_STATUS: rd_val[0]    = expired;
`ifdef WB_TIMER_CYCLECNT_EN
            REG_CYCLES: rd_val       = DATA_WIDTH'(cycles);
`endif
            default:    rd_val       = '0;
        endcase
    end

    always_ff @(posedge sys_clock_i) begin
        if (sys_reset_i) begin
            wbs_ack_o  <= 1'b0;
            wbs_data_o <= '0;
            en         <= 1'b0;
            periodic   <= 1'b0;
            irq_en     <= 1'b0;
            expired    <= 1'b0;
            load       <= '0;
            count      <= '0;
            presc      <= '0;
        end else begin
            wbs_ack_o  <= req;
            wbs_data_o <= (req && !wbs_we_i) ? rd_val : '0;

            if (en)
                presc <= tick ? '0 : presc + PW'(1);

            // A CTRL write clearing EN on the expiry tick suppresses the periodic reload.
            if (tick) begin
                if (count != '0)
                    count <= count - 32'd1;
                else if (!periodic)
                    en <= 1'b0;
                else if (!(ctrl_wr && !wbs_data_i[0]))
                    count <= load;
            end

            if (wr) begin
                case (reg_sel)
                    REG_CTRL: begin
                        if (wbs_sel_i[0]) begin
                            en       <= wbs_data_i[0];
                            periodic <= wbs_data_i[1];
                            irq_en   <= wbs_data_i[2];
                            if (!en && wbs_data_i[0]) begin
                                count <= load;
                                presc <= '0;
                            end
                        end
                    end
                    REG_LOAD:   load  <= merge(load, wbs_data_i[31:0], wbs_sel_i[3:0]);
                    REG_COUNT:  count <= merge(count, wbs_data_i[31:0], wbs_sel_i[3:0]);
                    REG_STATUS: if (wbs_sel_i[0] && wbs_data_i[0]) expired <= 1'b0;
                    default: ;
                endcase
            end

            // Set after the W1C clear so a same-cycle expiry wins.
            if (tick && (count == '0))
                expired <= 1'b1;
        end
    end
endmodule

// File: tb/tb_wb_timer.sv
// Self-checking bench for wb_timer: register table, corner sequences and randomized runs
// against an arithmetic (elapsed-ticks) model, on PRESCALE=1 and PRESCALE=4 instances.
module tb_wb_timer;
    localparam int DW = 64;
    localparam int AW = 64;
`ifdef WB_TIMER_CYCLECNT_EN
    localparam bit CC_EN = 1'b1;
`else
    localparam bit CC_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst[2];
    logic            cyc_s[2], stb_s[2], we_s[2];
    logic [AW-1:0]   addr_s[2];
    logic [DW-1:0]   wdat_s[2];
    logic [DW/8-1:0] sel_s[2];
    logic            ack_s[2], irq_s[2];
    logic [DW-1:0]   rdat_s[2];

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;
    always @(posedge clk) cycle <= cycle + 1;

    wb_timer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PRESCALE(1)) dut0 (
        .sys_clock_i(clk), .sys_reset_i(rst[0]), .wbs_cycle_i(cyc_s[0]),
        .wbs_strobe_i(stb_s[0]), .wbs_we_i(we_s[0]), .wbs_addr_i(addr_s[0]),
        .wbs_data_i(wdat_s[0]), .wbs_sel_i(sel_s[0]), .wbs_ack_o(ack_s[0]),
        .wbs_data_o(rdat_s[0]), .irq_o(irq_s[0]));

    wb_timer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PRESCALE(4)) dut1 (
        .sys_clock_i(clk), .sys_reset_i(rst[1]), .wbs_cycle_i(cyc_s[1]),
        .wbs_strobe_i(stb_s[1]), .wbs_we_i(we_s[1]), .wbs_addr_i(addr_s[1]),
        .wbs_data_i(wdat_s[1]), .wbs_sel_i(sel_s[1]), .wbs_ack_o(ack_s[1]),
        .wbs_data_o(rdat_s[1]), .irq_o(irq_s[1]));

    typedef struct {
        bit          we;
        int          a;
        logic [63:0] wd;
        logic [7:0]  be;
        logic [63:0] exp;
        bit          chk;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Timer state after edge e for a run enabled at edge t0 with LOAD=ld from a cleared state.
    function automatic void model(input int ld, input int p, input bit per, input int t0,
                                  input int e, output int cnt, output bit en, output bit ex);
        int k;
        k = (e - t0) / p;
        if (per) begin
            cnt = ld - (k % (ld + 1));
            en  = 1'b1;
            ex  = (k > ld);
        end else if (k <= ld) begin
            cnt = ld - k;
            en  = 1'b1;
            ex  = 1'b0;
        end else begin
            cnt = 0;
            en  = 1'b0;
            ex  = 1'b1;
        end
    endfunction

    // All tasks start and end just after a rising edge; the request is sampled at the next edge.
    task automatic xfer(input int d, input bit w, input int a, input logic [63:0] wd,
                        input logic [7:0] be, output logic [63:0] rd, output int tn);
        cyc_s[d] = 1'b1; stb_s[d] = 1'b1; we_s[d] = w;
        addr_s[d] = 64'(a) << 3; wdat_s[d] = wd; sel_s[d] = be;
        @(posedge clk); #1;
        tn = cycle;
        check("ack_rise", 64'(ack_s[d]), 64'd1);
        rd = rdat_s[d];
        cyc_s[d] = 1'b0; stb_s[d] = 1'b0; we_s[d] = 1'b0;
        @(posedge clk); #1;
        check("ack_width", 64'(ack_s[d]), 64'd0);
        check("data_idle", rdat_s[d], 64'd0);
    endtask

    task automatic wb_write(input int d, input int a, input logic [63:0] wd,
                            input logic [7:0] be, output int tn);
        logic [63:0] dummy;
        xfer(d, 1'b1, a, wd, be, dummy, tn);
    endtask

    task automatic wb_read(input int d, input int a, output logic [63:0] rd, output int tn);
        xfer(d, 1'b0, a, 64'd0, 8'hFF, rd, tn);
    endtask

    task automatic wait_to(input int target);
        int guard;
        guard = 0;
        while (cycle < target && guard < 1000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (cycle != target) begin
            checks++; failures++;
            $display("FAIL wait_to actual=%0d required=%0d", cycle, target);
        end
    endtask

    function automatic void add(input bit we, input int a, input logic [63:0] wd,
                                input logic [7:0] be, input logic [63:0] exp, input bit chk);
        vec_t v;
        v.we = we; v.a = a; v.wd = wd; v.be = be; v.exp = exp; v.chk = chk;
        vecs.push_back(v);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] r, r1;
        int tn, t0, tw, c, x, e1;

        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; cyc_s[d] = 1'b0; stb_s[d] = 1'b0; we_s[d] = 1'b0;
            addr_s[d] = '0; wdat_s[d] = '0; sel_s[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("reset_ack", 64'(ack_s[d]), 64'd0);
            check("reset_data", rdat_s[d], 64'd0);
            check("reset_irq", 64'(irq_s[d]), 64'd0);
            rst[d] = 1'b0;
        end

        // Register table on the PRESCALE=1 instance, timer disabled throughout.
        for (int a = 0; a < 8; a++) add(1'b0, a, 64'd0, 8'hFF, 64'd0, (a != 4) || !CC_EN);
        add(1'b1, 1, 64'hDEADBEEF_FFFFFFAB, 8'h00, 64'd0, 1'b0);
        add(1'b0, 1, 64'd0, 8'hFF, 64'd0, 1'b1);
        add(1'b1, 1, 64'h00000000_FFFFFFAB, 8'h01, 64'd0, 1'b0);
        add(1'b0, 1, 64'd0, 8'hFF, 64'h0000_00AB, 1'b1);
        add(1'b1, 1, 64'h00000000_A5A50000, 8'h0C, 64'd0, 1'b0);
        add(1'b0, 1, 64'd0, 8'hFF, 64'hA5A5_00AB, 1'b1);
        add(1'b1, 1, 64'hFFFFFFFF_12345678, 8'hFF, 64'd0, 1'b0);
        add(1'b0, 1, 64'd0, 8'hFF, 64'h1234_5678, 1'b1);
        add(1'b1, 2, 64'h9, 8'h0F, 64'd0, 1'b0);
        add(1'b0, 2, 64'd0, 8'hFF, 64'h9, 1'b1);
        add(1'b1, 2, 64'hFF00, 8'h02, 64'd0, 1'b0);
        add(1'b0, 2, 64'd0, 8'hFF, 64'hFF09, 1'b1);
        add(1'b1, 0, 64'h6, 8'h01, 64'd0, 1'b0);
        add(1'b0, 0, 64'd0, 8'hFF, 64'h6, 1'b1);
        add(1'b1, 0, 64'hFF, 8'h00, 64'd0, 1'b0);
        add(1'b0, 0, 64'd0, 8'hFF, 64'h6, 1'b1);
        add(1'b1, 0, 64'hFF01, 8'h02, 64'd0, 1'b0);
        add(1'b0, 0, 64'd0, 8'hFF, 64'h6, 1'b1);
        add(1'b1, 0, 64'h0, 8'h01, 64'd0, 1'b0);
        add(1'b0, 0, 64'd0, 8'hFF, 64'h0, 1'b1);
        add(1'b1, 5, '1, 8'hFF, 64'd0, 1'b0);
        add(1'b0, 5, 64'd0, 8'hFF, 64'd0, 1'b1);
        add(1'b1, 7, '1, 8'hFF, 64'd0, 1'b0);
        add(1'b0, 7, 64'd0, 8'hFF, 64'd0, 1'b1);
        add(1'b1, 4, '1, 8'hFF, 64'd0, 1'b0);
        add(1'b0, 4, 64'd0, 8'hFF, 64'd0, !CC_EN);
        add(1'b1, 3, 64'h1, 8'h01, 64'd0, 1'b0);
        add(1'b0, 3, 64'd0, 8'hFF, 64'd0, 1'b1);
        foreach (vecs[i]) begin
            xfer(0, vecs[i].we, vecs[i].a, vecs[i].wd, vecs[i].be, r, tn);
            if (!vecs[i].we && vecs[i].chk) check($sformatf("table%0d_a%0d", i, vecs[i].a), r, vecs[i].exp);
        end

        // Periodic LOAD=4: expiry 5 edges after enable, then W1C collision on an expiry edge.
        wb_write(0, 1, 64'd4, 8'hFF, tn);
        wb_write(0, 0, 64'h7, 8'h01, t0);
        wait_to(t0 + 4); check("per_irq_before", 64'(irq_s[0]), 64'd0);
        wait_to(t0 + 5); check("per_irq_at", 64'(irq_s[0]), 64'd1);
        for (int i = 0; i < 6; i++) begin
            int cnt; bit en, ex;
            wb_read(0, 2, r, tn);
            model(4, 1, 1'b1, t0, tn - 1, cnt, en, ex);
            check("per_count", r, 64'(cnt));
        end
        c = cycle;
        x = t0 + 5 * ((c - t0) / 5 + 2);
        wait_to(x - 4); wb_write(0, 3, 64'h1, 8'h01, tn);
        check("w1c_clears_irq", 64'(irq_s[0]), 64'd0);
        wait_to(x - 1); wb_write(0, 3, 64'h1, 8'h01, tn);
        check("w1c_vs_expiry_irq", 64'(irq_s[0]), 64'd1);
        wb_read(0, 3, r, tn); check("w1c_vs_expiry_status", r, 64'd1);
        wb_write(0, 0, 64'h0, 8'h01, tn);
        wb_write(0, 3, 64'h1, 8'h01, tn);

        // One-shot LOAD=2 with IRQ_EN.
        wb_write(0, 1, 64'd2, 8'hFF, tn);
        wb_write(0, 0, 64'h5, 8'h01, t0);
        wait_to(t0 + 2); check("os_irq_before", 64'(irq_s[0]), 64'd0);
        wait_to(t0 + 3); check("os_irq_at", 64'(irq_s[0]), 64'd1);
        wait_to(t0 + 6);
        wb_read(0, 0, r, tn); check("os_ctrl", r, 64'h4);
        wb_read(0, 2, r, tn); check("os_count", r, 64'd0);
        wb_read(0, 3, r, tn); check("os_status", r, 64'd1);
        check("os_irq_held", 64'(irq_s[0]), 64'd1);
        wb_write(0, 3, 64'h1, 8'h01, tn);
        check("os_irq_cleared", 64'(irq_s[0]), 64'd0);
        wb_read(0, 3, r, tn); check("os_status_cleared", r, 64'd0);

        // EN written 0 on the expiry edge of a periodic run: no reload.
        wb_write(0, 1, 64'd3, 8'hFF, tn);
        wb_write(0, 0, 64'h3, 8'h01, t0);
        wait_to(t0 + 3); wb_write(0, 0, 64'h2, 8'h01, tn);
        wb_read(0, 2, r, tn); check("en0_exp_count", r, 64'd0);
        wb_read(0, 0, r, tn); check("en0_exp_ctrl", r, 64'h2);
        wb_read(0, 3, r, tn); check("en0_exp_status", r, 64'd1);
        wb_write(0, 3, 64'h1, 8'h01, tn);

        // COUNT write beats the tick; LOAD write while running leaves COUNT alone.
        wb_write(0, 1, 64'd50, 8'hFF, tn);
        wb_write(0, 0, 64'h1, 8'h01, t0);
        wb_write(0, 2, 64'd100, 8'h0F, tw);
        wb_read(0, 2, r, tn); check("count_wr_wins", r, 64'(100 - (tn - 1 - tw)));
        wb_write(0, 1, 64'd7, 8'hFF, tn);
        wb_read(0, 2, r, tn); check("load_wr_running", r, 64'(100 - (tn - 1 - tw)));
        wb_write(0, 0, 64'h0, 8'h01, tn);

        // Held strobe: one ack every second cycle, data valid only with ack.
        cyc_s[0] = 1'b1; stb_s[0] = 1'b1; we_s[0] = 1'b0; addr_s[0] = 64'(1) << 3;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("held_ack", 64'(ack_s[0]), (i % 2 == 0) ? 64'd1 : 64'd0);
            check("held_data", rdat_s[0], (i % 2 == 0) ? 64'd7 : 64'd0);
        end
        cyc_s[0] = 1'b0; stb_s[0] = 1'b0;
        @(posedge clk); #1;

        // PRESCALE=4, LOAD=1 periodic: expiry every 8 edges; then reset during a write.
        wb_write(1, 1, 64'd1, 8'hFF, tn);
        wb_write(1, 0, 64'h7, 8'h01, t0);
        wait_to(t0 + 7);  check("p4_irq_before", 64'(irq_s[1]), 64'd0);
        wait_to(t0 + 8);  check("p4_irq_at", 64'(irq_s[1]), 64'd1);
        wait_to(t0 + 11); wb_write(1, 3, 64'h1, 8'h01, tn);
        check("p4_irq_cleared", 64'(irq_s[1]), 64'd0);
        wait_to(t0 + 15); check("p4_irq_before2", 64'(irq_s[1]), 64'd0);
        wait_to(t0 + 16); check("p4_irq_at2", 64'(irq_s[1]), 64'd1);
        wait_to(t0 + 18);
        rst[1] = 1'b1; cyc_s[1] = 1'b1; stb_s[1] = 1'b1; we_s[1] = 1'b1;
        addr_s[1] = 64'(1) << 3; wdat_s[1] = 64'h55; sel_s[1] = 8'hFF;
        @(posedge clk); #1;
        check("rst_ack", 64'(ack_s[1]), 64'd0);
        check("rst_data", rdat_s[1], 64'd0);
        check("rst_irq", 64'(irq_s[1]), 64'd0);
        rst[1] = 1'b0; cyc_s[1] = 1'b0; stb_s[1] = 1'b0; we_s[1] = 1'b0;
        wb_read(1, 2, r, tn); check("rst_count", r, 64'd0);
        wb_read(1, 0, r, tn); check("rst_ctrl", r, 64'd0);
        wb_read(1, 1, r, tn); check("rst_load_discarded", r, 64'd0);

`ifdef WB_TIMER_CYCLECNT_EN
        wb_read(0, 4, r1, e1);
        wait_to(e1 + 9);
        wb_read(0, 4, r, tn);
        check("cyclecnt_delta", r - r1, 64'd10);
`endif

        // Randomized runs checked against the elapsed-ticks model.
        for (int n = 0; n < 16; n++) begin
            int d, p, ld, rt, wt, a, cnt;
            bit per, ie, en, ex;
            d   = n % 2;
            p   = (d == 0) ? 1 : 4;
            ld  = int'($urandom_range(0, 5));
            per = 1'($urandom_range(0, 1));
            ie  = 1'($urandom_range(0, 1));
            wb_write(d, 0, 64'h0, 8'h01, tn);
            wb_write(d, 3, 64'h1, 8'h01, tn);
            wb_write(d, 1, 64'(ld), 8'hFF, tn);
            wb_write(d, 0, {61'd0, ie, per, 1'b1}, 8'h01, rt);
            for (int j = 0; j < 4; j++) begin
                wt = int'($urandom_range(0, 10));
                for (int q = 0; q < wt; q++) begin
                    @(posedge clk); #1;
                    model(ld, p, per, rt, cycle, cnt, en, ex);
                    check("rnd_irq", 64'(irq_s[d]), 64'(ie & ex));
                end
                case ($urandom_range(0, 2))
                    0:       a = 0;
                    1:       a = 2;
                    default: a = 3;
                endcase
                wb_read(d, a, r, tn);
                model(ld, p, per, rt, tn - 1, cnt, en, ex);
                if (a == 0)      check("rnd_ctrl", r, {61'd0, ie, per, en});
                else if (a == 2) check("rnd_count", r, 64'(cnt));
                else             check("rnd_status", r, 64'(ex));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
